// File: rtl/timer_share_arb.sv
// Round-robin arbiter sharing one CW-bit up-counter among NREQ requesters.
// Define TIMER_SHARE_ARB_FIXED_PRIO_EN for lowest-index-wins priority.
module timer_share_arb #(
  parameter int NREQ = 4,
  parameter int CW   = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NREQ-1:0]    REQ,
  input  logic [NREQ*CW-1:0] LEN,
  input  logic               ABORT,
  output logic [NREQ-1:0]    GNT,
  output logic               BUSY,
  output logic [CW-1:0]      CNT,
  output logic [NREQ-1:0]    DONE
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t          state;
  logic [CW-1:0]   target;
  logic [PW-1:0]   win;
  logic [PW-1:0]   pick;
  logic            found;
  logic [NREQ-1:0] pick_oh;
  logic [NREQ-1:0] win_oh;
  logic            quit;

`ifndef TIMER_SHARE_ARB_FIXED_PRIO_EN
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   nxt;
`endif

  // Winner search: first set REQ bit at or above the pointer, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef TIMER_SHARE_ARB_FIXED_PRIO_EN
      if (!found && REQ[k]) begin
        found = 1'b1;
        pick  = PW'(k);
      end
`else
      int j;
      j = int'(ptr) + k;
      if (j >= NREQ)
        j = j - NREQ;
      if (!found && REQ[j]) begin
        found = 1'b1;
        pick  = PW'(j);
      end
`endif
    end
  end

  // Grant vectors and abort condition for the running interval.
  always_comb begin
    pick_oh = NREQ'(1) << pick;
    win_oh  = NREQ'(1) << win;
    quit    = ABORT | ~REQ[win];
  end

`ifndef TIMER_SHARE_ARB_FIXED_PRIO_EN
  // Pointer moves just past the requester that was last served.
  always_comb begin
    if (win == PW'(NREQ - 1))
      nxt = '0;
    else
      nxt = win + PW'(1);
  end
`endif

  // Sequencer: IDLE grants, RUN counts to target, FIN pulses DONE.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state  <= IDLE;
      GNT    <= '0;
      DONE   <= '0;
      CNT    <= '0;
      BUSY   <= 1'b0;
      target <= '0;
      win    <= '0;
`ifndef TIMER_SHARE_ARB_FIXED_PRIO_EN
      ptr    <= '0;
`endif
    end else begin
      DONE <= '0;
      unique case (state)
        IDLE: begin
          if (found) begin
            state  <= RUN;
            GNT    <= pick_oh;
            CNT    <= '0;
            BUSY   <= 1'b1;
            win    <= pick;
            target <= LEN[pick*CW +: CW];
          end
        end
        RUN: begin
          if (quit) begin
            state <= IDLE;
            GNT   <= '0;
            CNT   <= '0;
            BUSY  <= 1'b0;
`ifndef TIMER_SHARE_ARB_FIXED_PRIO_EN
            ptr   <= nxt;
`endif
          end else if (CNT == target) begin
            state <= FIN;
            GNT   <= '0;
            DONE  <= win_oh;
          end else begin
            CNT <= CNT + CW'(1);
          end
        end
        FIN: begin
          state <= IDLE;
          BUSY  <= 1'b0;
          CNT   <= '0;
`ifndef TIMER_SHARE_ARB_FIXED_PRIO_EN
          ptr   <= nxt;
`endif
        end
        default: begin
          state <= IDLE;
          GNT   <= '0;
          CNT   <= '0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule
